// File: rtl/serial_compare_scheduler.sv
// serial_compare_scheduler
//   Shares one MSB-first serial magnitude comparator between NUM_REQ requesters.
//   A round-robin arbiter picks one requester with a pending (a, b) pair. Both
//   operands are then shifted through a bit-serial compare stage, and the
//   less/eq/greater result is returned with the requester index.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   req_valid    per-requester operand valid
//   req_ready    per-requester accept, at most one bit set
//   req_a/req_b  packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid    result valid, held until rsp_ready
//   rsp_ready    downstream accepts result
//   rsp_id       requester index of the current result
//   rsp_less/rsp_eq/rsp_greater  one-hot unsigned compare result
//   busy         transaction in flight (SHIFT or RESP)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | arbitrate; accept the granted requester's operand pair
// S_SHIFT | compare one bit per cycle, MSB first
// S_RESP  | present result, wait for rsp_ready
module serial_compare_scheduler #(
    parameter int WIDTH      = 8,
    parameter int NUM_REQ    = 2,
    parameter int EARLY_EXIT = 1,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic                       rsp_less,
    output logic                       rsp_eq,
    output logic                       rsp_greater,
    output logic                       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               prev_eq_q, prev_eq_d;
    logic               prev_less_q, prev_less_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic               rsp_less_q, rsp_less_d;
    logic               rsp_eq_q, rsp_eq_d;
    logic               rsp_greater_q, rsp_greater_d;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    int                 cand;
    logic               eq_n;
    logic               less_n;

    // Round-robin scan starting just after the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(rr_ptr_q) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign eq_n   = prev_eq_q & (a_sh_q[WIDTH-1] == b_sh_q[WIDTH-1]);
    assign less_n = prev_less_q | (prev_eq_q & ~a_sh_q[WIDTH-1] & b_sh_q[WIDTH-1]);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        a_sh_d        = a_sh_q;
        b_sh_d        = b_sh_q;
        bit_cnt_d     = bit_cnt_q;
        prev_eq_d     = prev_eq_q;
        prev_less_d   = prev_less_q;
        rsp_id_d      = rsp_id_q;
        rsp_less_d    = rsp_less_q;
        rsp_eq_d      = rsp_eq_q;
        rsp_greater_d = rsp_greater_q;
        req_ready     = '0;

        case (state_q)
            S_IDLE: begin
                // Ready is masked while reset is asserted so no requester sees
                // a handshake that the held-in-reset flops will never capture.
                if (grant_found && rst) begin
                    req_ready[grant_idx] = 1'b1;
                end
                if (grant_found) begin
                    state_d     = S_SHIFT;
                    rr_ptr_d    = grant_idx;
                    rsp_id_d    = grant_idx;
                    a_sh_d      = req_a[grant_idx*WIDTH +: WIDTH];
                    b_sh_d      = req_b[grant_idx*WIDTH +: WIDTH];
                    bit_cnt_d   = CNT_W'(WIDTH - 1);
                    prev_eq_d   = 1'b1;
                    prev_less_d = 1'b0;
                end
            end
            S_SHIFT: begin
                prev_eq_d   = eq_n;
                prev_less_d = less_n;
                a_sh_d      = {a_sh_q[WIDTH-2:0], 1'b0};
                b_sh_d      = {b_sh_q[WIDTH-2:0], 1'b0};
                bit_cnt_d   = bit_cnt_q - CNT_W'(1);
                if ((bit_cnt_q == '0) || ((EARLY_EXIT != 0) && !eq_n)) begin
                    state_d       = S_RESP;
                    rsp_less_d    = less_n;
                    rsp_eq_d      = eq_n;
                    rsp_greater_d = ~eq_n & ~less_n;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d       = S_IDLE;
                    rsp_less_d    = 1'b0;
                    rsp_eq_d      = 1'b0;
                    rsp_greater_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= ID_W'(NUM_REQ - 1);
            a_sh_q        <= '0;
            b_sh_q        <= '0;
            bit_cnt_q     <= '0;
            prev_eq_q     <= 1'b1;
            prev_less_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_less_q    <= 1'b0;
            rsp_eq_q      <= 1'b0;
            rsp_greater_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            a_sh_q        <= a_sh_d;
            b_sh_q        <= b_sh_d;
            bit_cnt_q     <= bit_cnt_d;
            prev_eq_q     <= prev_eq_d;
            prev_less_q   <= prev_less_d;
            rsp_id_q      <= rsp_id_d;
            rsp_less_q    <= rsp_less_d;
            rsp_eq_q      <= rsp_eq_d;
            rsp_greater_q <= rsp_greater_d;
        end
    end

    assign rsp_valid   = (state_q == S_RESP);
    assign busy        = (state_q != S_IDLE);
    assign rsp_id      = rsp_id_q;
    assign rsp_less    = rsp_less_q;
    assign rsp_eq      = rsp_eq_q;
    assign rsp_greater = rsp_greater_q;

endmodule
